// File: rtl/uart_pkg.sv
// Shared UART definitions: frame FSM states, data width and line levels.
package uart_pkg;

   localparam int unsigned UART_DATA_BITS = 8;

   localparam logic LINE_IDLE  = 1'b1;
   localparam logic LINE_START = 1'b0;
   localparam logic LINE_STOP  = 1'b1;

   typedef enum logic [2:0] {
      IDLE,
      LOAD,
      START,
      DATA,
      STOP
   } uart_state_e;

endpackage : uart_pkg

// File: rtl/uart_baud_cnt.sv
// Bit-period counter: counts 0..BAUD_DIV-1, pulses tick on the last count.
module uart_baud_cnt #(
   parameter int unsigned BAUD_DIV = 10416,
   localparam int unsigned CNT_W = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   output logic [CNT_W-1:0] cnt,
   output logic             tick
);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   assign tick = (cnt_q == CNT_W'(BAUD_DIV - 1));
   assign cnt  = cnt_q;

   always_comb begin
      cnt_d = cnt_q + CNT_W'(1);
      if (clr || tick) begin
         cnt_d = '0;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule : uart_baud_cnt

// File: rtl/fifo_uart_tx.sv
// FIFO read-side consumer: pops a byte whenever allowed and sends it as an 8N1 frame.
module fifo_uart_tx
   import uart_pkg::*;
#(
   parameter int unsigned BAUD_DIV = 10416,
   localparam int unsigned CNT_W = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       tx_en,
   input  logic       empty,
   input  logic [7:0] pop_data,
   output logic       pop,
   output logic       tx,
   output logic       tx_busy,
   output logic       tx_done
);

   localparam int unsigned IDX_W = $clog2(UART_DATA_BITS);

   uart_state_e         state_q, state_d;
   logic [7:0]          shift_q, shift_d;
   logic [IDX_W-1:0]    bit_idx_q, bit_idx_d;
   logic                tx_q, tx_d;
   logic                done_q, done_d;
   logic                baud_clr;
   logic                baud_tick;
   logic [CNT_W-1:0]    baud_cnt;

   uart_baud_cnt #(
      .BAUD_DIV (BAUD_DIV)
   ) u_baud (
      .clk  (clk),
      .rst  (rst),
      .clr  (baud_clr),
      .cnt  (baud_cnt),
      .tick (baud_tick)
   );

   assign tx      = tx_q;
   assign tx_done = done_q;
   assign tx_busy = (state_q != IDLE) || pop;

   // tx and tx_done are computed one cycle ahead so they leave a flop aligned with the state
   always_comb begin
      state_d   = state_q;
      shift_d   = shift_q;
      bit_idx_d = bit_idx_q;
      baud_clr  = 1'b0;
      pop       = 1'b0;
      done_d    = 1'b0;
      tx_d      = LINE_IDLE;

      unique case (state_q)
         IDLE: begin
            if (tx_en && !empty) begin
               pop     = 1'b1;
               state_d = LOAD;
            end
         end
         LOAD: begin
            shift_d   = pop_data;
            bit_idx_d = '0;
            baud_clr  = 1'b1;
            state_d   = START;
         end
         START: begin
            if (baud_tick) begin
               state_d = DATA;
            end
         end
         DATA: begin
            if (baud_tick) begin
               shift_d = shift_q >> 1;
               if (bit_idx_q == IDX_W'(UART_DATA_BITS - 1)) begin
                  state_d = STOP;
               end else begin
                  bit_idx_d = bit_idx_q + IDX_W'(1);
               end
            end
         end
         STOP: begin
            done_d = (baud_cnt == CNT_W'(BAUD_DIV - 2));
            if (baud_tick) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      unique case (state_d)
         START:   tx_d = LINE_START;
         DATA:    tx_d = shift_d[0];
         STOP:    tx_d = LINE_STOP;
         default: tx_d = LINE_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= IDLE;
         shift_q   <= '0;
         bit_idx_q <= '0;
         tx_q      <= LINE_IDLE;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         shift_q   <= shift_d;
         bit_idx_q <= bit_idx_d;
         tx_q      <= tx_d;
         done_q    <= done_d;
      end
   end

endmodule : fifo_uart_tx

// File: tb/tb_fifo_uart_tx.sv
// Bench for fifo_uart_tx: behavioural FIFO plus a frame-timing reference model checked every cycle.
module tb_fifo_uart_tx;

   localparam int unsigned B         = 4;
   localparam int          FRAME_END = 1 + 10 * B;

   logic       clk;
   logic       rst;
   logic       tx_en;
   logic       empty;
   logic [7:0] pop_data;
   logic       pop;
   logic       tx;
   logic       tx_busy;
   logic       tx_done;

   fifo_uart_tx #(
      .BAUD_DIV (B)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .tx_en    (tx_en),
      .empty    (empty),
      .pop_data (pop_data),
      .pop      (pop),
      .tx       (tx),
      .tx_busy  (tx_busy),
      .tx_done  (tx_done)
   );

   int         checks      = 0;
   int         failures    = 0;
   logic [7:0] fifo[$];
   logic [7:0] mq[$];
   int         m_pos       = -1;
   logic [7:0] m_byte      = 8'h00;
   logic       do_pop      = 1'b0;
   int         dut_pops    = 0;
   int         model_pops  = 0;
   int         underflows  = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
      end
   endtask

   // Line level p cycles after the pop cycle of a frame carrying byte b
   function automatic logic exp_line(input int p, input logic [7:0] b);
      int k;
      if (p < 2) return 1'b1;
      k = (p - 2) / int'(B);
      if (k == 0) return 1'b0;
      if (k <= 8) return b[k-1];
      return 1'b1;
   endfunction

   always @(negedge clk) begin : model_chk
      logic e_pop;
      logic e_tx;
      e_pop = 1'b0;
      if (!rst) begin
         m_pos = -1;
      end else if (m_pos < 0 && tx_en && mq.size() > 0) begin
         m_byte = mq.pop_front();
         m_pos  = 0;
         e_pop  = 1'b1;
         model_pops++;
      end
      e_tx = (m_pos < 0) ? 1'b1 : exp_line(m_pos, m_byte);
      check("pop", pop, e_pop);
      check("tx", tx, e_tx);
      check("tx_busy", tx_busy, m_pos >= 0);
      check("tx_done", tx_done, m_pos == FRAME_END);
      do_pop = pop;
      if (pop) dut_pops++;
      if (m_pos >= 0) begin
         m_pos++;
         if (m_pos > FRAME_END) m_pos = -1;
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
      if (do_pop) begin
         if (fifo.size() > 0) pop_data = fifo.pop_front();
         else underflows++;
      end
      empty = (fifo.size() == 0);
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   task automatic push(input logic [7:0] b);
      fifo.push_back(b);
      mq.push_back(b);
      empty = 1'b0;
   endtask

   initial begin
      rst      = 1'b1;
      tx_en    = 1'b0;
      empty    = 1'b1;
      pop_data = 8'h00;
      #1 rst = 1'b0;
      #3;
      check("rst_tx", tx, 1'b1);
      check("rst_pop", pop, 1'b0);
      check("rst_busy", tx_busy, 1'b0);
      check("rst_done", tx_done, 1'b0);
      run(3);
      rst   = 1'b1;
      tx_en = 1'b1;

      // single byte
      push(8'hA5);
      run(50);

      // back-to-back frames
      push(8'h00);
      push(8'hFF);
      run(100);

      // empty FIFO
      run(200);

      // tx_en dropped mid-frame
      push(8'h3C);
      push(8'h55);
      for (int i = 0; i < 100 && !(m_pos >= 2 + int'(B)); i++) step();
      check("wait_data", m_pos >= 2 + int'(B), 1'b1);
      tx_en = 1'b0;
      run(80);
      check("hold_fifo", fifo.size(), 1);
      tx_en = 1'b1;
      run(50);

      // reset during data bit 3
      push(8'h81);
      push(8'h5A);
      for (int i = 0; i < 100 && !(m_pos == 3 + 4 * int'(B)); i++) step();
      check("wait_bit3", m_pos == 3 + 4 * int'(B), 1'b1);
      rst   = 1'b0;
      tx_en = 1'b0;
      #1;
      check("async_tx", tx, 1'b1);
      check("async_busy", tx_busy, 1'b0);
      run(3);
      rst   = 1'b1;
      tx_en = 1'b1;
      run(60);

      // randomized traffic with tx_en toggling
      for (int i = 0; i < 25; i++) begin
         int n;
         n = int'($urandom_range(0, 3));
         for (int j = 0; j < n; j++) push(8'($urandom));
         tx_en = ($urandom_range(0, 3) != 0);
         run(int'($urandom_range(5, 60)));
      end

      tx_en = 1'b1;
      for (int i = 0; i < 6000 && !(mq.size() == 0 && fifo.size() == 0 && m_pos < 0); i++) step();
      check("drain", mq.size() == 0 && fifo.size() == 0 && m_pos < 0, 1'b1);
      run(5);
      check("pop_count", dut_pops, model_pops);
      check("underflow", underflows, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule : tb_fifo_uart_tx
